// File: rtl/dtw_hit_filter.sv
// Reduces each query's DTW cost stream to a two-word match record: {min_cost} then {hit, min_pos}.
// Optional macro DTW_HIT_FILTER_DROP_EN discards records whose minimum cost exceeds the threshold.
module dtw_hit_filter #(
    parameter int width = 32,
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] threshold,
    input  logic [width-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [width-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [31:0]      query_cnt,
    output logic [31:0]      hit_cnt,
    output logic             busy
);

    // Handshake: a word moves on the rising edge where tvalid and tready are both high;
    // once m_axis_tvalid rises, it and the data stay put until m_axis_tready is seen.
    typedef enum logic [1:0] {
        ACCUM      = 2'd0,
        EMIT_SCORE = 2'd1,
        EMIT_POS   = 2'd2
    } state_t;

    localparam logic [POS_W-1:0] POS_MAX = {POS_W{1'b1}};

    state_t             state_q;
    logic               first_q;
    logic [width-1:0]   min_cost_q;
    logic [POS_W-1:0]   min_pos_q;
    logic [POS_W-1:0]   pos_q;
    logic [width-1:0]   thr_q;
    logic               hit_q;
    logic               s_ready_q;
    logic               m_valid_q;
    logic [width-1:0]   m_data_q;
    logic               m_last_q;
    logic [31:0]        query_cnt_q;
    logic [31:0]        hit_cnt_q;

    logic               in_fire;
    logic [width-1:0]   thr_d;
    logic [width-1:0]   min_cost_d;
    logic [POS_W-1:0]   min_pos_d;
    logic [POS_W-1:0]   pos_d;
    logic               hit_d;
    logic [width-1:0]   pos_word;

    always_comb begin
        in_fire    = s_axis_tvalid && s_ready_q;
        thr_d      = first_q ? threshold : thr_q;
        min_cost_d = min_cost_q;
        min_pos_d  = min_pos_q;
        pos_d      = (pos_q == POS_MAX) ? pos_q : pos_q + POS_W'(1);
        if (first_q) begin
            min_cost_d = s_axis_tdata;
            min_pos_d  = '0;
            pos_d      = POS_W'(1);
        end else if (s_axis_tdata < min_cost_q) begin
            // strict compare so ties keep the earliest position
            min_cost_d = s_axis_tdata;
            min_pos_d  = pos_q;
        end
        hit_d                 = (min_cost_d <= thr_d);
        pos_word              = '0;
        pos_word[width-1]     = hit_q;
        pos_word[POS_W-1:0]   = min_pos_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            first_q     <= 1'b1;
            min_cost_q  <= '0;
            min_pos_q   <= '0;
            pos_q       <= '0;
            thr_q       <= '0;
            hit_q       <= 1'b0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            query_cnt_q <= '0;
            hit_cnt_q   <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    s_ready_q <= 1'b1;
                    if (in_fire) begin
                        min_cost_q <= min_cost_d;
                        min_pos_q  <= min_pos_d;
                        pos_q      <= pos_d;
                        thr_q      <= thr_d;
                        first_q    <= 1'b0;
                        if (s_axis_tlast) begin
                            first_q <= 1'b1;
                            hit_q   <= hit_d;
`ifdef DTW_HIT_FILTER_DROP_EN
                            if (!hit_d) begin
                                query_cnt_q <= query_cnt_q + 32'd1;
                            end else begin
                                state_q   <= EMIT_SCORE;
                                s_ready_q <= 1'b0;
                                m_valid_q <= 1'b1;
                                m_data_q  <= min_cost_d;
                                m_last_q  <= 1'b0;
                            end
`else
                            state_q   <= EMIT_SCORE;
                            s_ready_q <= 1'b0;
                            m_valid_q <= 1'b1;
                            m_data_q  <= min_cost_d;
                            m_last_q  <= 1'b0;
`endif
                        end
                    end
                end
                EMIT_SCORE: begin
                    if (m_axis_tready) begin
                        state_q  <= EMIT_POS;
                        m_data_q <= pos_word;
                        m_last_q <= 1'b1;
                    end
                end
                EMIT_POS: begin
                    if (m_axis_tready) begin
                        state_q     <= ACCUM;
                        s_ready_q   <= 1'b1;
                        m_valid_q   <= 1'b0;
                        m_last_q    <= 1'b0;
                        query_cnt_q <= query_cnt_q + 32'd1;
                        if (hit_q) hit_cnt_q <= hit_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q   <= ACCUM;
                    s_ready_q <= 1'b1;
                    m_valid_q <= 1'b0;
                    m_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign query_cnt     = query_cnt_q;
    assign hit_cnt       = hit_cnt_q;
    assign busy          = (state_q != ACCUM) || !first_q;

endmodule

// File: tb/tb_dtw_hit_filter.sv
// Directed bench for dtw_hit_filter: record contents, latency, backpressure, saturation, reset abort.
module tb_dtw_hit_filter;

    logic        clk;
    logic        rst;
    logic [31:0] threshold;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [31:0] query_cnt;
    logic [31:0] hit_cnt;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // expected record words: bit 32 is tlast, bits 31:0 are tdata
    logic [32:0] exp_q[$];

    dtw_hit_filter #(.width(32), .POS_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .threshold     (threshold),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .query_cnt     (query_cnt),
        .hit_cnt       (hit_cnt),
        .busy          (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic send_word(input logic [31:0] d, input logic last);
        int n;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        n = 0;
        @(negedge clk);
        while (!s_axis_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic push_rec(input logic [31:0] score, input logic [31:0] posw);
        exp_q.push_back({1'b0, score});
        exp_q.push_back({1'b1, posw});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every output handshake is matched against the expected queue
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                chk("rec_extra", 32'd0, 32'd1);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rec_data", m_axis_tdata, e[31:0]);
                chk("rec_last", {31'd0, m_axis_tlast}, {31'd0, e[32]});
            end
        end
    end

    initial begin
        rst           = 1'b1;
        threshold     = 32'd0;
        s_axis_tdata  = 32'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;

        @(posedge clk);
        #1;
        chk("rst_s_ready", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_m_valid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_m_data", m_axis_tdata, 32'd0);
        chk("rst_m_last", {31'd0, m_axis_tlast}, 32'd0);
        chk("rst_qcnt", query_cnt, 32'd0);
        chk("rst_hcnt", hit_cnt, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_s_ready", {31'd0, s_axis_tready}, 32'd1);

        // hit with a tie at positions 1 and 3; latency checked cycle by cycle
        threshold = 32'd5;
        push_rec(32'd4, 32'h8000_0001);
        send_word(32'd9, 1'b0);
        chk("busy_mid", {31'd0, busy}, 32'd1);
        send_word(32'd4, 1'b0);
        send_word(32'd7, 1'b0);
        send_word(32'd4, 1'b0);
        send_word(32'd12, 1'b1);
        @(negedge clk);
        chk("lat_score_valid", {31'd0, m_axis_tvalid}, 32'd1);
        chk("lat_score_last", {31'd0, m_axis_tlast}, 32'd0);
        chk("emit_s_ready", {31'd0, s_axis_tready}, 32'd0);
        @(negedge clk);
        chk("lat_pos_valid", {31'd0, m_axis_tvalid}, 32'd1);
        chk("lat_pos_last", {31'd0, m_axis_tlast}, 32'd1);
        @(negedge clk);
        chk("lat_ready_back", {31'd0, s_axis_tready}, 32'd1);
        chk("lat_valid_low", {31'd0, m_axis_tvalid}, 32'd0);
        wait_drain();
        chk("t1_qcnt", query_cnt, 32'd1);
        chk("t1_hcnt", hit_cnt, 32'd1);

        // miss; threshold raised mid-query must not count
        threshold = 32'd3;
`ifndef DTW_HIT_FILTER_DROP_EN
        push_rec(32'd4, 32'h0000_0001);
`endif
        send_word(32'd9, 1'b0);
        threshold = 32'd100;
        send_word(32'd4, 1'b0);
        send_word(32'd7, 1'b0);
        send_word(32'd4, 1'b0);
        send_word(32'd12, 1'b1);
        wait_drain();
        chk("t2_qcnt", query_cnt, 32'd2);
        chk("t2_hcnt", hit_cnt, 32'd1);

        // single-word query, equality is a hit
        threshold = 32'h10;
        push_rec(32'h10, 32'h8000_0000);
        send_word(32'h10, 1'b1);
        wait_drain();
        chk("t3_qcnt", query_cnt, 32'd3);
        chk("t3_hcnt", hit_cnt, 32'd2);

        // backpressure during the score word
        threshold = 32'd50;
        m_axis_tready = 1'b0;
        push_rec(32'd3, 32'h8000_0001);
        send_word(32'd8, 1'b0);
        send_word(32'd3, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, m_axis_tvalid}, 32'd1);
            chk("bp_data", m_axis_tdata, 32'd3);
            chk("bp_last", {31'd0, m_axis_tlast}, 32'd0);
            chk("bp_s_ready", {31'd0, s_axis_tready}, 32'd0);
        end
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        chk("rel_score", {31'd0, m_axis_tvalid, m_axis_tlast}, 32'd2);
        @(negedge clk);
        chk("rel_pos", {31'd0, m_axis_tvalid, m_axis_tlast}, 32'd3);
        wait_drain();
        chk("t4_qcnt", query_cnt, 32'd4);
        chk("t4_hcnt", hit_cnt, 32'd3);

        // position counter saturation
        threshold = 32'd0;
        push_rec(32'd0, 32'h8000_FFFF);
        for (int i = 0; i < 70000; i++) begin
            send_word((i == 69999) ? 32'd0 : 32'd1, (i == 69999));
        end
        wait_drain();
        chk("t5_qcnt", query_cnt, 32'd5);
        chk("t5_hcnt", hit_cnt, 32'd4);

        // reset mid-query: the zeros sent before reset must not survive
        send_word(32'd0, 1'b0);
        send_word(32'd0, 1'b0);
        send_word(32'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_qcnt", query_cnt, 32'd0);
        chk("mid_rst_hcnt", hit_cnt, 32'd0);
        chk("mid_rst_s_ready", {31'd0, s_axis_tready}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        threshold = 32'd4;
        push_rec(32'd2, 32'h8000_0001);
        send_word(32'd5, 1'b0);
        send_word(32'd2, 1'b1);
        wait_drain();
        chk("t6_qcnt", query_cnt, 32'd1);
        chk("t6_hcnt", hit_cnt, 32'd1);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
